dds_qwave_sweep: RTL and testbench

//  Parametrised direct digital synthesiser: phase accumulator, phase offset, quarter-wave sine LUT.

---
 rtl/dds_qwave_sweep_pkg.sv | 46 ++++
 rtl/dds_qwave_sweep_rom.sv | 28 ++
 rtl/dds_qwave_sweep.sv | 114 +++++++++++
 tb/tb_dds_qwave_sweep.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dds_qwave_sweep_pkg.sv
// Shared types, quadrant helpers and the quarter-wave sine generator for dds_qwave_sweep.
package dds_qwave_sweep_pkg;

  typedef enum logic [1:0] {
    TONE  = 2'd0,
    SWEEP = 2'd1,
    HOLD  = 2'd2
  } sweep_state_e;

  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  localparam int          FRAC_BITS    = 60;
  localparam int          TAYLOR_TERMS = 12;
  localparam logic [63:0] PI_Q60       = 64'h3243_F6A8_885A_308D;

  // Falling quadrants read the table backwards.
  function automatic logic quad_mirrored(input logic [1:0] q);
    return (q == QUAD_1) || (q == QUAD_3);
  endfunction

  function automatic logic quad_negative(input logic [1:0] q);
    return (q == QUAD_2) || (q == QUAD_3);
  endfunction

  // round((2^(data_w-1)-1) * sin((idx+0.5)*pi/2^(addr_w-1))) using a Q60 Taylor series.
  function automatic int unsigned qtr_sine_mag(input int unsigned idx,
                                               input int unsigned addr_w,
                                               input int unsigned data_w);
    logic [127:0] x, x2, term, sum_pos, sum_neg, amp;
    x       = (((128'(idx) << 1) + 128'd1) * 128'(PI_Q60)) >> addr_w;
    x2      = (x * x) >> FRAC_BITS;
    term    = x;
    sum_pos = x;
    sum_neg = '0;
    for (int k = 1; k <= TAYLOR_TERMS; k++) begin
      term = ((term * x2) >> FRAC_BITS) / 128'((2 * k) * (2 * k + 1));
      if (k % 2 == 1) sum_neg = sum_neg + term;
      else            sum_pos = sum_pos + term;
    end
    amp = (128'd1 << (data_w - 1)) - 128'd1;
    return 32'((((sum_pos - sum_neg) * amp) + (128'd1 << (FRAC_BITS - 1))) >> FRAC_BITS);
  endfunction

endpackage

// File: rtl/dds_qwave_sweep_rom.sv
// Synchronous quarter-wave sine ROM: 2^(ADDR_W-2) magnitudes of DATA_W-1 bits, one read per clk.
module dds_qwave_sweep_rom
  import dds_qwave_sweep_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-3:0] addr,
  output logic [DATA_W-2:0] mag
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  logic [DATA_W-2:0] rom_table [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_table
    assign rom_table[i] = (DATA_W - 1)'(qtr_sine_mag(int'(i), ADDR_W, DATA_W));
  end

  // NOTE: the table is constant logic and is never reset; only the read register is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mag <= '0;
    else        mag <= rom_table[addr];
  end

endmodule

// File: rtl/dds_qwave_sweep.sv
// DDS with runtime tuning word, linear frequency sweep and a 3-stage quarter-wave sine pipeline.
module dds_qwave_sweep
  import dds_qwave_sweep_pkg::*;
#(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              phase_clr,
  input  logic [ACC_W-1:0]  ftw_in,
  input  logic              ftw_load,
  input  logic [ACC_W-1:0]  pow_in,
  input  logic              sweep_start,
  input  logic [ACC_W-1:0]  sweep_step,
  input  logic [ACC_W-1:0]  sweep_stop,
  output logic [DATA_W-1:0] sine,
  output logic              upper_half,
  output logic              sample_valid,
  output logic              sweep_busy,
  output logic              sweep_done
);

  localparam int IDX_W     = ADDR_W - 2;
  localparam int VALID_DLY = 4;  // en edge, S1, S2, S3

  sweep_state_e         state, state_next;
  logic [ACC_W-1:0]     acc, ftw_active, ftw_next, phase;
  logic [ACC_W:0]       sweep_sum;
  logic                 done_next;
  logic [1:0]           phase_quad, s1_q, s2_q;
  logic [IDX_W-1:0]     phase_idx, s1_idx;
  logic [DATA_W-2:0]    mag;
  logic                 s2_neg;
  logic [VALID_DLY-1:0] valid_sr;

  assign phase        = acc + pow_in;
  assign phase_quad   = phase[ACC_W-1 -: 2];
  assign phase_idx    = phase[ACC_W-3 -: IDX_W];
  assign s2_neg       = quad_negative(s2_q);
  assign sweep_busy   = (state == SWEEP);
  assign sample_valid = valid_sr[VALID_DLY-1];

  always_comb begin
    // NOTE: every output of this block is given a default first so no path can infer a latch.
    state_next = state;
    ftw_next   = ftw_active;
    done_next  = 1'b0;
    sweep_sum  = {1'b0, ftw_active} + {1'b0, sweep_step};
    if (sweep_start) begin
      ftw_next   = ftw_in;
      state_next = SWEEP;
    end else if (ftw_load) begin
      ftw_next   = ftw_in;
      state_next = TONE;
    end else if (state == SWEEP && en) begin
      // The extra carry bit lets a huge step clamp instead of wrapping below the stop value.
      if (sweep_sum >= {1'b0, sweep_stop}) begin
        ftw_next   = sweep_stop;
        state_next = HOLD;
        done_next  = 1'b1;
      end else begin
        ftw_next = sweep_sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= TONE;
      ftw_active <= '0;
      sweep_done <= 1'b0;
      acc        <= '0;
    end else begin
      // NOTE: non-blocking updates so the accumulator sees the pre-edge tuning word.
      state      <= state_next;
      ftw_active <= ftw_next;
      sweep_done <= done_next;
      if (phase_clr) acc <= '0;
      else if (en)   acc <= acc + ftw_active;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_idx     <= '0;
      s2_q       <= '0;
      sine       <= {1'b1, {(DATA_W-1){1'b0}}};
      upper_half <= 1'b1;
      valid_sr   <= '0;
    end else begin
      s1_q       <= phase_quad;
      s1_idx     <= quad_mirrored(phase_quad) ? ~phase_idx : phase_idx;
      s2_q       <= s1_q;
      sine       <= {~s2_neg, s2_neg ? ~mag : mag};
      upper_half <= ~s2_neg;
      valid_sr   <= {valid_sr[VALID_DLY-2:0], en};
    end
  end

  dds_qwave_sweep_rom #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_rom (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (s1_idx),
    .mag  (mag)
  );

endmodule

// File: tb/tb_dds_qwave_sweep.sv
// Randomised scoreboard bench for dds_qwave_sweep against a real-arithmetic sine/sweep model.
module tb_dds_qwave_sweep;

  localparam real PI = 3.14159265358979323846;

  typedef struct packed {
    logic [13:0] sine;
    logic        uh;
  } sample_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, phase_clr, ftw_load, sweep_start;
  logic [31:0] ftw_in, pow_in, sweep_step, sweep_stop;
  logic [13:0] sine;
  logic        upper_half, sample_valid, sweep_busy, sweep_done;

  int n_checks = 0;
  int n_pass   = 0;

  dds_qwave_sweep dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .phase_clr   (phase_clr),
    .ftw_in      (ftw_in),
    .ftw_load    (ftw_load),
    .pow_in      (pow_in),
    .sweep_start (sweep_start),
    .sweep_step  (sweep_step),
    .sweep_stop  (sweep_stop),
    .sine        (sine),
    .upper_half  (upper_half),
    .sample_valid(sample_valid),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Ideal full-cycle sine at the bin centre of the top 14 phase bits, offset-binary.
  function automatic sample_t model_sample(input logic [31:0] ph);
    int      j, mag;
    real     v;
    sample_t r;
    j   = int'(ph >> 18);
    v   = $sin((real'(j) + 0.5) * PI / 8192.0);
    mag = $rtoi(8191.0 * (v < 0.0 ? -v : v) + 0.5);
    if (v >= 0.0) begin
      r.sine = 14'(8192 + mag);
      r.uh   = 1'b1;
    end else begin
      r.sine = 14'(8191 - mag);
      r.uh   = 1'b0;
    end
    return r;
  endfunction

  // Reference model: phase and tuning word as plain numbers, sweep as a single "sweeping" flag.
  logic [31:0]     m_acc = '0, m_ftw = '0;
  bit              m_sweeping = 1'b0, m_done = 1'b0, m_pending = 1'b0;
  longint unsigned m_next;
  sample_t         exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc      = '0;
      m_ftw      = '0;
      m_sweeping = 1'b0;
      m_done     = 1'b0;
      m_pending  = 1'b0;
      exp_q.delete();
    end else begin
      if (m_pending) exp_q.push_back(model_sample(m_acc + pow_in));
      m_pending = en;
      m_done    = 1'b0;
      if (phase_clr) m_acc = '0;
      else if (en)   m_acc = m_acc + m_ftw;
      if (sweep_start) begin
        m_ftw      = ftw_in;
        m_sweeping = 1'b1;
      end else if (ftw_load) begin
        m_ftw      = ftw_in;
        m_sweeping = 1'b0;
      end else if (m_sweeping && en) begin
        m_next = longint'(m_ftw) + longint'(sweep_step);
        if (m_next >= longint'(sweep_stop)) begin
          m_ftw      = sweep_stop;
          m_sweeping = 1'b0;
          m_done     = 1'b1;
        end else begin
          m_ftw = m_next[31:0];
        end
      end
    end
  end

  // Monitor: status every cycle, samples whenever the DUT flags one.
  sample_t got;
  always @(negedge clk) begin
    if (rst_n) begin
      check("sweep_busy", 64'(sweep_busy), 64'(m_sweeping));
      check("sweep_done", 64'(sweep_done), 64'(m_done));
      if (sample_valid) begin
        check("sample_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          check("sine", 64'(sine), 64'(got.sine));
          check("upper_half", 64'(upper_half), 64'(got.uh));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [31:0] ftw);
    ftw_in   = ftw;
    ftw_load = 1'b1;
    step();
    ftw_load = 1'b0;
  endtask

  // Expects en=1 sampled at the next edge with an empty pipeline.
  task automatic latency_probe(input string tag);
    repeat (3) step();
    check({tag, "_valid_early"}, 64'(sample_valid), 64'd0);
    step();
    check({tag, "_valid_on_time"}, 64'(sample_valid), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sine"}, 64'(sine), 64'd8192);
    check({tag, "_upper_half"}, 64'(upper_half), 64'd1);
    check({tag, "_valid"}, 64'(sample_valid), 64'd0);
    check({tag, "_busy"}, 64'(sweep_busy), 64'd0);
    check({tag, "_done"}, 64'(sweep_done), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; phase_clr = 1'b0; ftw_load = 1'b0; sweep_start = 1'b0;
    ftw_in = '0; pow_in = '0; sweep_step = '0; sweep_stop = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // Quarter-rate tone: 8194, 16383, 8189, 0 repeating, then half-cycle offset.
    pulse_load(32'h4000_0000);
    en = 1'b1;
    latency_probe("tone");
    repeat (10) step();
    pow_in = 32'h8000_0000;
    repeat (8) step();
    pow_in = '0;

    // Linear sweep 1..4 x 2^24.
    ftw_in = 32'h0100_0000; sweep_step = 32'h0100_0000; sweep_stop = 32'h0400_0000;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    repeat (8) step();

    // Simultaneous events and clamp without wrap.
    ftw_in = 32'h0000_1234; sweep_stop = 32'h8000_0000; sweep_step = 32'h0010_0000;
    sweep_start = 1'b1; ftw_load = 1'b1;
    step();
    sweep_start = 1'b0; ftw_load = 1'b0;
    repeat (3) step();
    phase_clr = 1'b1;
    step();
    phase_clr = 1'b0;
    repeat (2) step();
    ftw_in = 32'h0000_0005; sweep_step = 32'hFFFF_FFFF; sweep_stop = 32'hFFFF_FFFF;
    sweep_start = 1'b1;
    step();
    sweep_start = 1'b0;
    repeat (4) step();

    // Descending phase with en toggling.
    pulse_load(32'hFFFF_FFFF);
    repeat (6) step();
    pulse_load(32'hC000_0000);
    for (int i = 0; i < 16; i++) begin
      en = 1'(($urandom_range(0, 1)));
      step();
    end
    en = 1'b1;
    repeat (4) step();

    // Asynchronous reset mid-run.
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    latency_probe("post_reset");

    for (int i = 0; i < 2000; i++) begin
      en          = ($urandom_range(0, 3) != 0);
      phase_clr   = ($urandom_range(0, 31) == 0);
      ftw_load    = ($urandom_range(0, 31) == 0);
      sweep_start = ($urandom_range(0, 39) == 0);
      if (ftw_load || sweep_start)
        ftw_in = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 32'h0400_0000);
      if (sweep_start) begin
        sweep_step = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 32'h0200_0000);
        sweep_stop = $urandom;
      end
      if ($urandom_range(0, 15) == 0) pow_in = $urandom;
      step();
    end

    en = 1'b0; phase_clr = 1'b0; ftw_load = 1'b0; sweep_start = 1'b0;
    repeat (8) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
